// File: rtl/outpkt_cksum_insert_pkg.sv
// Shared definitions for the output-packet checksum stage: header geometry,
// checksum width, pkt_comm output packet type codes, FSM state type and the
// little-endian 16-to-32-bit pairing accumulator.
package outpkt_cksum_insert_pkg;

    localparam int HEADER_WORDS_DEF = 5;
    localparam int HEADER_BYTES     = 10;
    localparam int SUM_W            = 32;

    typedef enum logic [7:0] {
        OUTPKT_D1 = 8'hD1,
        OUTPKT_D2 = 8'hD2,
        OUTPKT_D3 = 8'hD3
    } outpkt_type_e;

    typedef enum logic [2:0] {
        S_DATA   = 3'd0,
        S_HCS_LO = 3'd1,
        S_HCS_HI = 3'd2,
        S_DCS_LO = 3'd3,
        S_DCS_HI = 3'd4
    } cks_state_e;

    // Adds one 16-bit word into a 32-bit modulo sum; the first word of each
    // pair is the low half, the second the high half.
    function automatic logic [SUM_W-1:0] cksum_acc32(
        input logic [SUM_W-1:0] sum,
        input logic             half,
        input logic [15:0]      word
    );
        logic [SUM_W-1:0] addend;
        if (half) begin
            addend = {word, 16'h0000};
        end else begin
            addend = {16'h0000, word};
        end
        return sum + addend;
    endfunction

endpackage

// File: rtl/outpkt_cksum_insert.sv
// Output-packet checksum inserter: passes header/data words through a
// one-entry output register and injects ~sum checksums (low half first)
// after the header and after the data of every packet.
module outpkt_cksum_insert
    import outpkt_cksum_insert_pkg::*;
#(
    parameter int HEADER_WORDS = HEADER_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] din,
    input  logic        pkt_new,
    input  logic        pkt_end,
    input  logic        wr_en,
    output logic        full,
    output logic [15:0] dout,
    input  logic        rd_en,
    output logic        empty
);

    // Counter saturates at HEADER_WORDS, which marks "now in data words".
    localparam int CNT_W = $clog2(HEADER_WORDS + 1);

    cks_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_word_cnt, w_word_cnt_nxt, w_cnt_base;
    logic [SUM_W-1:0] r_sum, w_sum_nxt, w_sum_base, w_sum_acc;
    logic [SUM_W-1:0] r_cs, w_cs_nxt;
    logic             r_half, w_half_nxt, w_half_base;
    logic             r_end_pend, w_end_pend_nxt;
    logic             r_valid, w_valid_nxt;
    logic [15:0]      r_dout, w_dout_nxt;
    logic             w_load_ok, w_full, w_accept, w_hdr_last, w_is_data;

    // Next-state, output-register and accumulator logic.
    always_comb begin
        w_load_ok   = ~r_valid | rd_en;
        // pkt_new restarts counting and summing with the current word.
        w_cnt_base  = pkt_new ? {CNT_W{1'b0}} : r_word_cnt;
        w_sum_base  = pkt_new ? {SUM_W{1'b0}} : r_sum;
        w_half_base = pkt_new ? 1'b0 : r_half;
        w_sum_acc   = cksum_acc32(w_sum_base, w_half_base, din);
        w_hdr_last  = (w_cnt_base == CNT_W'(HEADER_WORDS - 1));
        w_is_data   = (w_cnt_base >= CNT_W'(HEADER_WORDS));

        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_sum_nxt      = r_sum;
        w_cs_nxt       = r_cs;
        w_half_nxt     = r_half;
        w_end_pend_nxt = r_end_pend;
        w_dout_nxt     = r_dout;
        w_valid_nxt    = r_valid & ~rd_en;
        w_full         = 1'b1;
        w_accept       = 1'b0;

        case (r_state)
            S_DATA: begin
                w_full   = ~w_load_ok;
                w_accept = wr_en & w_load_ok;
                if (w_accept) begin
                    w_dout_nxt  = din;
                    w_valid_nxt = 1'b1;
                    w_sum_nxt   = w_sum_acc;
                    w_half_nxt  = ~w_half_base;
                    if (w_is_data) begin
                        w_word_cnt_nxt = w_cnt_base;
                    end else begin
                        w_word_cnt_nxt = w_cnt_base + CNT_W'(1);
                    end
                    if (w_hdr_last) begin
                        w_state_nxt    = S_HCS_LO;
                        w_cs_nxt       = ~w_sum_acc;
                        w_sum_nxt      = {SUM_W{1'b0}};
                        w_half_nxt     = 1'b0;
                        w_end_pend_nxt = pkt_end;
                    end else if (w_is_data && pkt_end) begin
                        w_state_nxt = S_DCS_LO;
                        w_cs_nxt    = ~w_sum_acc;
                        w_sum_nxt   = {SUM_W{1'b0}};
                        w_half_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_HCS_LO, S_DCS_LO: begin
                if (w_load_ok) begin
                    w_dout_nxt  = r_cs[15:0];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = (r_state == S_HCS_LO) ? S_HCS_HI : S_DCS_HI;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_HCS_HI: begin
                if (w_load_ok) begin
                    w_dout_nxt  = r_cs[31:16];
                    w_valid_nxt = 1'b1;
                    if (r_end_pend) begin
                        // Empty data section: checksum of nothing is ~0.
                        w_state_nxt    = S_DCS_LO;
                        w_cs_nxt       = {SUM_W{1'b1}};
                        w_end_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_HCS_HI;
                end
            end
            S_DCS_HI: begin
                if (w_load_ok) begin
                    w_dout_nxt     = r_cs[31:16];
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_DATA;
                    w_word_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = S_DCS_HI;
                end
            end
            default: begin
                w_state_nxt = S_DATA;
            end
        endcase
    end

    // State, counters, checksum and output register update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_DATA;
            r_word_cnt <= {CNT_W{1'b0}};
            r_sum      <= {SUM_W{1'b0}};
            r_cs       <= {SUM_W{1'b0}};
            r_half     <= 1'b0;
            r_end_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_dout     <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_sum      <= w_sum_nxt;
            r_cs       <= w_cs_nxt;
            r_half     <= w_half_nxt;
            r_end_pend <= w_end_pend_nxt;
            r_valid    <= w_valid_nxt;
            r_dout     <= w_dout_nxt;
        end
    end

    assign full  = RST | w_full;
    assign dout  = r_dout;
    assign empty = ~r_valid;

endmodule

// File: tb/tb_outpkt_cksum_insert.sv
// Self-checking bench for outpkt_cksum_insert: directed packets from the
// pkt_comm examples plus randomized traffic, all compared against a
// packet-level checksum model through an expected-word queue.
module tb_outpkt_cksum_insert;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] din;
    logic        pkt_new, pkt_end, wr_en, rd_en;
    logic        full, empty;
    logic [15:0] dout;

    int checks = 0;
    int errors = 0;
    int full_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] pw[0:63];
    int          plen;
    bit          abort_pkt;
    logic [15:0] out_w[0:79];
    int          out_len;

    outpkt_cksum_insert dut (
        .CLK(CLK), .RST(RST), .din(din), .pkt_new(pkt_new), .pkt_end(pkt_end),
        .wr_en(wr_en), .full(full), .dout(dout), .rd_en(rd_en), .empty(empty)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Scoreboard: every word actually read from the DUT must be the next expected one.
    always @(negedge CLK) begin
        if (!RST && !empty && rd_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h required=none", dout);
            end else begin
                check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    // Counts cycles where the stage refuses input.
    always @(negedge CLK) begin
        if (!RST && full) full_cnt++;
    end

    // Packet-level model: header words, ~sum(header), data words, ~sum(data).
    task automatic model_pkt();
        longint hs = 0;
        longint ds = 0;
        logic [31:0] c;
        out_len = 0;
        for (int i = 0; i < plen; i++) begin
            out_w[out_len] = pw[i];
            out_len++;
            if (i < 5) hs += longint'(pw[i]) * (((i % 2) == 1) ? 65536 : 1);
            else       ds += longint'(pw[i]) * ((((i - 5) % 2) == 1) ? 65536 : 1);
            if (i == 4 && !abort_pkt) begin
                c = ~32'(hs);
                out_w[out_len] = c[15:0];  out_w[out_len+1] = c[31:16];
                out_len += 2;
            end
        end
        if (!abort_pkt) begin
            c = ~32'(ds);
            out_w[out_len] = c[15:0];  out_w[out_len+1] = c[31:16];
            out_len += 2;
        end
        for (int i = 0; i < out_len; i++) exp_q.push_back(out_w[i]);
    endtask

    // Drives pw[0..plen-1]; stall_at >= 0 forces a 5-cycle read stall there.
    task automatic send_pkt(input int rd_pct, input int wr_pct, input int stall_at);
        int idx = 0;
        int cyc = 0;
        int stall_left = (stall_at >= 0) ? 5 : 0;
        bit stalling;
        while (idx < plen) begin
            @(posedge CLK); #1;
            rd_en = ($urandom_range(0, 99) < rd_pct);
            wr_en = ($urandom_range(0, 99) < wr_pct);
            stalling = (idx == stall_at) && (stall_left > 0);
            if (stalling) begin
                rd_en = 1'b0;
                wr_en = 1'b1;
            end
            din     = pw[idx];
            pkt_new = (idx == 0);
            pkt_end = (idx == plen - 1) && !abort_pkt;
            @(negedge CLK);
            if (stalling) begin
                check("stall_full", 32'(full), 32'd1);
                check("stall_empty", 32'(empty), 32'd0);
                check("stall_dout_hold", 32'(dout), 32'(pw[stall_at-1]));
                stall_left--;
            end
            if (wr_en && !full) idx++;
            cyc++;
            if (cyc > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout accepted=%0d required=%0d", idx, plen);
                break;
            end
        end
        @(posedge CLK); #1;
        wr_en = 1'b0; pkt_new = 1'b0; pkt_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            wr_en = 1'b0; rd_en = 1'b1; pkt_new = 1'b0; pkt_end = 1'b0;
        end
    endtask

    task automatic load_hdr();
        pw[0] = 16'hD202; pw[1] = 16'h0000; pw[2] = 16'h0004;
        pw[3] = 16'h0000; pw[4] = 16'h0001;
    endtask

    initial begin
        logic [15:0] lit1 [0:10];
        int fbase;
        int waitc;
        lit1 = '{16'hD202, 16'h0000, 16'h0004, 16'h0000, 16'h0001, 16'h2DF8,
                 16'hFFFF, 16'h0002, 16'h0001, 16'hFFFD, 16'hFFFE};
        RST = 1'b1; din = 16'h0000; pkt_new = 1'b0; pkt_end = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; abort_pkt = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd1);
        check("rst_dout", 32'(dout), 32'h0);
        @(posedge CLK); #1; RST = 1'b0; rd_en = 1'b1;
        @(negedge CLK);
        check("post_rst_full", 32'(full), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);

        // PACKET_DONE example; full must rise for exactly 4 cycles.
        load_hdr(); pw[5] = 16'h0002; pw[6] = 16'h0001; plen = 7;
        model_pkt();
        for (int i = 0; i < 11; i++) check("model_pin_p1", 32'(out_w[i]), 32'(lit1[i]));
        check("model_pin_p1_len", 32'(out_len), 32'd11);
        fbase = full_cnt;
        send_pkt(100, 100, -1);
        idle(6);
        check("p1_full_cycles", 32'(full_cnt - fbase), 32'd4);

        // Data 4x FFFF: sum wraps, checksum 0001,0000.
        load_hdr(); for (int i = 5; i < 9; i++) pw[i] = 16'hFFFF; plen = 9;
        model_pkt();
        check("model_pin_wrap_lo", 32'(out_w[out_len-2]), 32'h0001);
        check("model_pin_wrap_hi", 32'(out_w[out_len-1]), 32'h0000);
        send_pkt(100, 100, -1);

        // Odd data: trailing word zero-extended.
        load_hdr(); pw[5] = 16'h1111; pw[6] = 16'h2222; pw[7] = 16'h3333; plen = 8;
        model_pkt();
        check("model_pin_odd_lo", 32'(out_w[out_len-2]), 32'hBBBB);
        check("model_pin_odd_hi", 32'(out_w[out_len-1]), 32'hDDDD);
        send_pkt(100, 100, -1);

        // Read stall mid-header.
        load_hdr(); pw[5] = 16'hABCD; pw[6] = 16'h1234; plen = 7;
        model_pkt();
        send_pkt(100, 100, 3);

        // pkt_end on last header word: empty data checksum FFFF,FFFF.
        load_hdr(); plen = 5;
        model_pkt();
        check("model_pin_nodata_lo", 32'(out_w[out_len-2]), 32'hFFFF);
        check("model_pin_nodata_hi", 32'(out_w[out_len-1]), 32'hFFFF);
        send_pkt(100, 100, -1);

        // Aborted packet (pkt_new mid-header) followed by a clean one.
        abort_pkt = 1'b1;
        pw[0] = 16'hD101; pw[1] = 16'h5555; pw[2] = 16'h7777; plen = 3;
        model_pkt();
        send_pkt(100, 100, -1);
        abort_pkt = 1'b0;
        load_hdr(); pw[5] = 16'h0F0F; plen = 6;
        model_pkt();
        send_pkt(100, 100, -1);
        idle(6);

        // Reset while the data checksum is pending.
        load_hdr(); pw[5] = 16'h4444; pw[6] = 16'h8888; plen = 7;
        model_pkt();
        send_pkt(100, 100, -1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("dcs_rst_empty", 32'(empty), 32'd1);
        check("dcs_rst_dout", 32'(dout), 32'h0);
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("dcs_rst_full", 32'(full), 32'd0);
        load_hdr(); pw[5] = 16'h0002; pw[6] = 16'h0001; plen = 7;
        model_pkt();
        send_pkt(100, 100, -1);

        // Randomized traffic with read/write back-pressure.
        for (int p = 0; p < 40; p++) begin
            plen = $urandom_range(5, 12);
            for (int i = 0; i < plen; i++)
                pw[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            model_pkt();
            send_pkt(70, 80, -1);
        end

        // Drain.
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 500) begin
            @(posedge CLK); #1;
            rd_en = 1'b1; wr_en = 1'b0;
            waitc++;
        end
        idle(2);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        check("drain_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
